// File: rtl/dmem_arb_pkg.sv
// Shared types and funct3 encodings for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } arb_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // One registered response slot; port selects which pN_rvalid/pN_err fires.
  typedef struct packed {
    logic valid;
    logic err;
    logic port;
  } resp_t;

endpackage

// File: rtl/dmem_req_check.sv
// Combinational legality check of a memory request: range, alignment and
// funct3/direction validity.
module dmem_req_check #(
  parameter int unsigned ADDR_WORDS = 32
) (
  input  logic [31:0] i_addr,
  input  logic        i_we,
  input  logic [2:0]  i_func3,
  output logic        o_legal_c
);
  import dmem_arb_pkg::*;

  localparam int unsigned BYTES = 4 * ADDR_WORDS;

  logic w_range_ok;
  logic w_align_ok;
  logic w_store_ok;

  assign w_range_ok = (i_addr < 32'(BYTES));

  // Alignment per access size; reserved encodings are never aligned.
  always_comb begin
    w_align_ok = 1'b0;
    case (i_func3)
      F3_B, F3_BU: w_align_ok = 1'b1;
      F3_H, F3_HU: w_align_ok = ~i_addr[0];
      F3_W:        w_align_ok = (i_addr[1:0] == 2'b00);
      default:     w_align_ok = 1'b0;
    endcase
  end

  assign w_store_ok = ~i_we | (i_func3 == F3_B) | (i_func3 == F3_H) | (i_func3 == F3_W);
  assign o_legal_c  = w_range_ok & w_align_ok & w_store_ok;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port data memory.
// Optional port-1 bus lock is built when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter #(
  parameter int unsigned ADDR_WORDS = 32
`ifdef DMEM_ARB_LOCK_EN
  , parameter int unsigned LOCK_MAX = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [2:0]  p0_func3,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [2:0]  p1_func3,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic        p0_err,
  output logic        p1_err,
  output logic [31:0] rdata,
  output logic        mem_wr,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_wr,
  output logic [2:0]  mem_func3,
  output logic [1:0]  mem_col,
  input  logic [31:0] mem_data
`ifdef DMEM_ARB_LOCK_EN
  , input  logic      p1_lock
`endif
);
  import dmem_arb_pkg::*;

`ifdef DMEM_ARB_LOCK_EN
  localparam int unsigned CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  arb_state_e       r_state;
  logic [CNT_W-1:0] r_lock_cnt;
`endif

  logic        r_last_gnt;
  resp_t       r_resp;
  logic [31:0] r_rdata;

  logic        w_pick0;
  logic        w_pick1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_any;
  logic        w_legal;
  logic        w_go;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [2:0]  w_func3;
  resp_t       w_resp;

  // Round-robin pick; a locked port 1 excludes port 0 entirely.
  always_comb begin
    w_pick0 = 1'b0;
    w_pick1 = 1'b0;
    if (p0_req && p1_req) begin
      w_pick0 = r_last_gnt;
      w_pick1 = ~r_last_gnt;
    end else begin
      w_pick0 = p0_req;
      w_pick1 = p1_req;
    end
`ifdef DMEM_ARB_LOCK_EN
    if (r_state == LOCK1) begin
      w_pick0 = 1'b0;
      w_pick1 = p1_req;
    end
`endif
  end

  // No grant (hence no memory write) can escape while reset is asserted.
  assign w_gnt0 = w_pick0 & rst_n;
  assign w_gnt1 = w_pick1 & rst_n;
  assign w_any  = w_gnt0 | w_gnt1;
  assign p0_gnt = w_gnt0;
  assign p1_gnt = w_gnt1;

  assign w_we    = w_gnt1 ? p1_we    : p0_we;
  assign w_addr  = w_gnt1 ? p1_addr  : p0_addr;
  assign w_wdata = w_gnt1 ? p1_wdata : p0_wdata;
  assign w_func3 = w_gnt1 ? p1_func3 : p0_func3;

  dmem_req_check #(
    .ADDR_WORDS (ADDR_WORDS)
  ) u_req_check (
    .i_addr    (w_addr),
    .i_we      (w_we),
    .i_func3   (w_func3),
    .o_legal_c (w_legal)
  );

  // Memory only sees legal granted accesses; otherwise the bus is parked at zero.
  assign w_go        = w_any & w_legal;
  assign mem_wr      = w_go & w_we;
  assign mem_read    = w_go & ~w_we;
  assign mem_addr    = w_go ? w_addr  : 32'd0;
  assign mem_data_wr = w_go ? w_wdata : 32'd0;
  assign mem_func3   = w_go ? w_func3 : 3'd0;
  assign mem_col     = mem_addr[1:0];

  always_comb begin
    w_resp       = '0;
    w_resp.valid = w_any;
    w_resp.err   = w_any & ~w_legal;
    w_resp.port  = w_gnt1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= 1'b1;
      r_resp     <= '0;
      r_rdata    <= 32'd0;
`ifdef DMEM_ARB_LOCK_EN
      r_state    <= ARB;
      r_lock_cnt <= '0;
`endif
    end else begin
      r_resp <= w_resp;
      if (w_any) begin
        r_last_gnt <= w_gnt1;
        r_rdata    <= (w_legal && !w_we) ? mem_data : 32'd0;
      end
`ifdef DMEM_ARB_LOCK_EN
      case (r_state)
        ARB: begin
          r_lock_cnt <= '0;
          if (w_gnt1 && p1_lock) r_state <= LOCK1;
        end
        LOCK1: begin
          if ((w_gnt1 && !p1_lock) || (!p1_lock && !p1_req)) begin
            r_state    <= ARB;
            r_lock_cnt <= '0;
          end else if (r_lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
            // Forced release hands the next tie to port 0.
            r_state    <= ARB;
            r_lock_cnt <= '0;
            r_last_gnt <= 1'b1;
          end else begin
            r_lock_cnt <= r_lock_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state    <= ARB;
          r_lock_cnt <= '0;
        end
      endcase
`endif
    end
  end

  assign p0_rvalid = r_resp.valid & ~r_resp.port;
  assign p1_rvalid = r_resp.valid &  r_resp.port;
  assign p0_err    = r_resp.err   & ~r_resp.port;
  assign p1_err    = r_resp.err   &  r_resp.port;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p1_req, p0_we, p1_we;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic [2:0]  p0_func3, p1_func3;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [31:0] rdata;
  logic        mem_wr, mem_read;
  logic [31:0] mem_addr, mem_data_wr, mem_data;
  logic [2:0]  mem_func3;
  logic [1:0]  mem_col;
`ifdef DMEM_ARB_LOCK_EN
  logic        p1_lock;
`endif

  int n_checks;
  int n_fail;

  logic [31:0] mem [32];
  logic [31:0] rd_word;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;

  dmem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p0_req      (p0_req),
    .p0_we       (p0_we),
    .p0_addr     (p0_addr),
    .p0_wdata    (p0_wdata),
    .p0_func3    (p0_func3),
    .p1_req      (p1_req),
    .p1_we       (p1_we),
    .p1_addr     (p1_addr),
    .p1_wdata    (p1_wdata),
    .p1_func3    (p1_func3),
    .p0_gnt      (p0_gnt),
    .p1_gnt      (p1_gnt),
    .p0_rvalid   (p0_rvalid),
    .p1_rvalid   (p1_rvalid),
    .p0_err      (p0_err),
    .p1_err      (p1_err),
    .rdata       (rdata),
    .mem_wr      (mem_wr),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_data_wr (mem_data_wr),
    .mem_func3   (mem_func3),
    .mem_col     (mem_col),
    .mem_data    (mem_data)
`ifdef DMEM_ARB_LOCK_EN
    , .p1_lock   (p1_lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-lane write memory
  always @(posedge clk) begin
    if (mem_wr) begin
      case (mem_func3)
        3'b000:  mem[mem_addr[6:2]][8*mem_col +: 8] <= mem_data_wr[7:0];
        3'b001:  mem[mem_addr[6:2]][16*mem_col[1] +: 16] <= mem_data_wr[15:0];
        default: mem[mem_addr[6:2]] <= mem_data_wr;
      endcase
    end
  end

  // Combinational extended read
  always_comb begin
    rd_word  = mem[mem_addr[6:2]];
    rd_b     = rd_word[8*mem_col +: 8];
    rd_h     = rd_word[16*mem_col[1] +: 16];
    mem_data = rd_word;
    case (mem_func3)
      3'b000:  mem_data = {{24{rd_b[7]}}, rd_b};
      3'b100:  mem_data = {24'd0, rd_b};
      3'b001:  mem_data = {{16{rd_h[15]}}, rd_h};
      3'b101:  mem_data = {16'd0, rd_h};
      default: mem_data = rd_word;
    endcase
  end

  task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3,
                       output logic g0, output logic g1, output logic mwr, output logic mrd,
                       output logic rv0, output logic rv1, output logic e0, output logic e1,
                       output logic [31:0] rd);
    @(negedge clk);
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd; p1_func3 = f3;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd; p0_func3 = f3;
    end
    #1;
    g0 = p0_gnt; g1 = p1_gnt; mwr = mem_wr; mrd = mem_read;
    @(posedge clk);
    #1;
    rv0 = p0_rvalid; rv1 = p1_rvalid; e0 = p0_err; e1 = p1_err; rd = rdata;
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h0; p0_wdata = 32'h1234_5678; p0_func3 = 3'b010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h4; p1_wdata = 32'h0; p1_func3 = 3'b010;
    @(posedge clk);
    #1;
    n_checks++; if ({p0_gnt, p1_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", {p0_gnt, p1_gnt}); end
    n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
    n_checks++; if ({p0_rvalid, p1_rvalid, p0_err, p1_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_resp: got %b want 0000", {p0_rvalid, p1_rvalid, p0_err, p1_err}); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
    n_checks++; if (mem[0] !== 32'h0) begin n_fail++; $display("FAIL reset_no_write: got %h want 00000000", mem[0]); end
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic g0, g1, mwr, mrd, rv0, rv1, e0, e1;
    logic [31:0] rd;
    issue(1'b0, 1'b1, 32'h08, 32'hDEAD_BEEF, 3'b010, g0, g1, mwr, mrd, rv0, rv1, e0, e1, rd);
    n_checks++; if ({g0, g1, mwr, mrd} !== 4'b1010) begin n_fail++; $display("FAIL sw_grant: got %b want 1010", {g0, g1, mwr, mrd}); end
    n_checks++; if ({rv0, rv1, e0, rd} !== {3'b100, 32'h0}) begin n_fail++; $display("FAIL sw_resp: got %b/%h want 100/00000000", {rv0, rv1, e0}, rd); end
    n_checks++; if (mem[2] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_mem: got %h want deadbeef", mem[2]); end
    issue(1'b0, 1'b0, 32'h08, 32'h0, 3'b010, g0, g1, mwr, mrd, rv0, rv1, e0, e1, rd);
    n_checks++; if ({g0, g1, mwr, mrd} !== 4'b1001) begin n_fail++; $display("FAIL lw_grant: got %b want 1001", {g0, g1, mwr, mrd}); end
    n_checks++; if ({rv0, rv1, e0} !== 3'b100) begin n_fail++; $display("FAIL lw_resp: got %b want 100", {rv0, rv1, e0}); end
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
    @(posedge clk);
    #1;
    n_checks++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rvalid_pulse: got %b want 00", {p0_rvalid, p1_rvalid}); end
  endtask

  task automatic test_tie();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h08; p0_func3 = 3'b010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h10; p1_func3 = 3'b010;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if ({p0_gnt, p1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL tie_gnt%0d: got %b want %b", i, {p0_gnt, p1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      if (i > 0) begin
        n_checks++; if ({p0_rvalid, p1_rvalid} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL tie_rvalid%0d: got %b want %b", i, {p0_rvalid, p1_rvalid}, (i % 2 == 1) ? 2'b10 : 2'b01); end
        n_checks++; if (rdata !== ((i % 2 == 1) ? 32'hDEAD_BEEF : 32'h0)) begin n_fail++; $display("FAIL tie_rdata%0d: got %h want %h", i, rdata, (i % 2 == 1) ? 32'hDEAD_BEEF : 32'h0); end
      end
      @(negedge clk);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    #1;
    n_checks++; if ({p0_rvalid, p1_rvalid, p1_err} !== 3'b010) begin n_fail++; $display("FAIL tie_last_resp: got %b want 010", {p0_rvalid, p1_rvalid, p1_err}); end
  endtask

  task automatic test_byte_half();
    logic g0, g1, mwr, mrd, rv0, rv1, e0, e1;
    logic [31:0] rd;
    logic [2:0]  f3s [7];
    logic [31:0] adrs [7];
    logic [31:0] exps [7];
    issue(1'b0, 1'b1, 32'h10, 32'h8000_FF80, 3'b010, g0, g1, mwr, mrd, rv0, rv1, e0, e1, rd);
    issue(1'b1, 1'b1, 32'h13, 32'h0000_0012, 3'b000, g0, g1, mwr, mrd, rv0, rv1, e0, e1, rd);
    n_checks++; if ({g1, mwr, rv1, e1} !== 4'b1110) begin n_fail++; $display("FAIL sb_p1: got %b want 1110", {g1, mwr, rv1, e1}); end
    issue(1'b1, 1'b1, 32'h7C, 32'hA5A5_0001, 3'b010, g0, g1, mwr, mrd, rv0, rv1, e0, e1, rd);
    f3s[0] = 3'b000; adrs[0] = 32'h10; exps[0] = 32'hFFFF_FF80;
    f3s[1] = 3'b100; adrs[1] = 32'h11; exps[1] = 32'h0000_00FF;
    f3s[2] = 3'b001; adrs[2] = 32'h12; exps[2] = 32'h1200_0000 >> 16 | 32'hFFFF_0000 & 32'h0;
    f3s[3] = 3'b101; adrs[3] = 32'h10; exps[3] = 32'h0000_FF80;
    f3s[4] = 3'b010; adrs[4] = 32'h10; exps[4] = 32'h1200_FF80;
    f3s[5] = 3'b010; adrs[5] = 32'h7C; exps[5] = 32'hA5A5_0001;
    f3s[6] = 3'b000; adrs[6] = 32'h7F; exps[6] = 32'hFFFF_FFA5;
    // Byte 0x13 now holds 0x12, so LH 0x12 returns 0x00001200
    exps[2] = 32'h0000_1200;
    for (int i = 0; i < 7; i++) begin
      issue(i[0], 1'b0, adrs[i], 32'h0, f3s[i], g0, g1, mwr, mrd, rv0, rv1, e0, e1, rd);
      n_checks++; if ({rv0 | rv1, e0 | e1, rd} !== {2'b10, exps[i]}) begin n_fail++; $display("FAIL load%0d: got v%b e%b %h want v1 e0 %h", i, rv0 | rv1, e0 | e1, rd, exps[i]); end
    end
    // Sign-extended half before the SB overwrite path
    issue(1'b0, 1'b1, 32'h18, 32'h8000_FF80, 3'b010, g0, g1, mwr, mrd, rv0, rv1, e0, e1, rd);
    issue(1'b0, 1'b0, 32'h1A, 32'h0, 3'b001, g0, g1, mwr, mrd, rv0, rv1, e0, e1, rd);
    n_checks++; if (rd !== 32'hFFFF_8000) begin n_fail++; $display("FAIL lh_sext: got %h want ffff8000", rd); end
    @(posedge clk);
    #1;
    n_checks++; if ({p0_rvalid, rdata} !== {1'b0, 32'hFFFF_8000}) begin n_fail++; $display("FAIL rdata_hold: got v%b %h want v0 ffff8000", p0_rvalid, rdata); end
  endtask

  task automatic test_illegal();
    logic g0, g1, mwr, mrd, rv0, rv1, e0, e1;
    logic [31:0] rd;
    logic [31:0] adrs [5];
    logic        wes  [5];
    logic [2:0]  f3s  [5];
    adrs[0] = 32'h06; wes[0] = 1'b0; f3s[0] = 3'b010;
    adrs[1] = 32'h03; wes[1] = 1'b0; f3s[1] = 3'b001;
    adrs[2] = 32'h80; wes[2] = 1'b1; f3s[2] = 3'b010;
    adrs[3] = 32'h00; wes[3] = 1'b0; f3s[3] = 3'b011;
    adrs[4] = 32'h10; wes[4] = 1'b1; f3s[4] = 3'b100;
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, wes[i], adrs[i], 32'hBAD0_BAD0, f3s[i], g0, g1, mwr, mrd, rv0, rv1, e0, e1, rd);
      n_checks++; if ({g1, mwr, mrd} !== 3'b100) begin n_fail++; $display("FAIL illegal%0d_mem: got gnt%b wr%b rd%b want 100", i, g1, mwr, mrd); end
      n_checks++; if ({rv0, rv1, e1, rd} !== {3'b011, 32'h0}) begin n_fail++; $display("FAIL illegal%0d_resp: got %b %h want 011 00000000", i, {rv0, rv1, e1}, rd); end
    end
    n_checks++; if (mem[4] !== 32'h1200_FF80) begin n_fail++; $display("FAIL illegal_mem_kept: got %h want 1200ff80", mem[4]); end
    n_checks++; if (mem[0] !== 32'h0) begin n_fail++; $display("FAIL illegal_mem0: got %h want 00000000", mem[0]); end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h08; p0_func3 = 3'b010;
    @(posedge clk);
    #1;
    p0_req = 1'b0;
    rst_n  = 1'b0;
    #1;
    n_checks++; if ({p0_rvalid, p1_rvalid, rdata} !== {2'b00, 32'h0}) begin n_fail++; $display("FAIL midop_drop: got %b %h want 00 00000000", {p0_rvalid, p1_rvalid}, rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL midop_post: got %b want 00", {p0_rvalid, p1_rvalid}); end
    @(negedge clk);
    p0_req = 1'b1; p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h10; p1_func3 = 3'b010;
    #1;
    n_checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin n_fail++; $display("FAIL midop_tie: got %b want 10", {p0_gnt, p1_gnt}); end
    @(negedge clk);
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

`ifdef DMEM_ARB_LOCK_EN
  task automatic test_lock();
    int starve;
    int p1_cnt;
    logic got;
    starve = 0; p1_cnt = 0; got = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h08; p0_func3 = 3'b010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h10; p1_func3 = 3'b010; p1_lock = 1'b1;
    #1;
    n_checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin n_fail++; $display("FAIL lock_first: got %b want 10", {p0_gnt, p1_gnt}); end
    @(negedge clk);
    #1;
    n_checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin n_fail++; $display("FAIL lock_enter: got %b want 01", {p0_gnt, p1_gnt}); end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      #1;
      if (p0_gnt) got = 1'b1;
      else begin
        starve++;
        if (p1_gnt) p1_cnt++;
      end
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL lock_release: got %b want 1", got); end
    n_checks++; if (starve != 16) begin n_fail++; $display("FAIL lock_starve: got %0d want 16", starve); end
    n_checks++; if (p1_cnt != 16) begin n_fail++; $display("FAIL lock_p1_grants: got %0d want 16", p1_cnt); end
    p0_req = 1'b0; p1_req = 1'b0; p1_lock = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0; p0_func3 = 3'b0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0; p1_func3 = 3'b0;
`ifdef DMEM_ARB_LOCK_EN
    p1_lock = 1'b0;
`endif
    test_reset();
    test_single();
    test_tie();
    test_byte_half();
    test_illegal();
    test_reset_midop();
`ifdef DMEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port data memory (32 x 32-bit words, byte/half/word access selected by func3). It shares the memory between port 0 (core load/store stage) and port 1 (debug/DMA loader).
- Round-robin arbitration on ties.
- Rejects illegal or misaligned requests without touching memory.
- Returns a registered one-cycle-later response (read data or write ack) to the winning port.

Parameters:
ADDR_WORDS, 32, number of 32-bit memory words; byte-address range is 0 .. 4*ADDR_WORDS-1.
LOCK_MAX, 16, maximum consecutive cycles port 1 may hold a lock (only with DMEM_ARB_LOCK_EN).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
p0_req / p1_req  in  1  access request; held with its fields until pN_gnt
p0_we / p1_we  in  1  1=store, 0=load
p0_addr / p1_addr  in  32  byte address
p0_wdata / p1_wdata  in  32  store data (unshifted, low bytes)
p0_func3 / p1_func3  in  3  RISC-V load/store funct3
p0_gnt / p1_gnt  out  1  combinational grant; request consumed this cycle
p0_rvalid / p1_rvalid  out  1  response strobe, cycle after grant
p0_err / p1_err  out  1  qualifies rvalid: request was illegal
rdata  out  32  shared response data (sign/zero extended load result)
mem_wr, mem_read  out  1 each  memory write/read enables
mem_addr  out  32  memory byte address
mem_data_wr  out  32  memory store data
mem_func3  out  3  memory funct3
mem_col  out  2  byte column = mem_addr[1:0]
mem_data  in  32  memory combinational read result
p1_lock  in  1  lock request (only with DMEM_ARB_LOCK_EN)

Behaviour:
Reset (rst_n low, asynchronous):
- All gnt/rvalid/err = 0, rdata = 0.
- last_gnt = 1, so port 0 wins the first tie.
- State = ARB, lock_cnt = 0.
- While rst_n is low, gnt and mem_wr are forced 0, so no write can occur.

Selection (combinational, state ARB):
- Only one req high: grant that port.
- Both req high: grant the port != last_gnt.
- last_gnt updates on every edge that carries a grant.
- At most one gnt per cycle.

Grant and handshake:
- gnt is a one-cycle pulse.
- A req still high on the next cycle is a new access.
- Back-to-back grants are allowed every cycle. The response to grant N is presented in cycle N+1, concurrently with grant N+1.

Legality check (granted request). The request is illegal if any of the following holds:
- addr >= 4*ADDR_WORDS.
- func3 is half (001/101) and addr[0] = 1.
- func3 is word (010) and addr[1:0] != 0.
- func3 is 011/110/111.
- we = 1 and func3 is not in {000, 001, 010}.

Memory drive:
- Legal grant: mem_addr = addr, mem_col = addr[1:0], mem_func3 = func3, mem_data_wr = wdata, mem_wr = we, mem_read = !we.
- Illegal grant or no grant: mem_wr = mem_read = 0, mem_addr = 0, mem_data_wr = 0, mem_func3 = 0.

Response (registered at the grant edge):
- In cycle N+1, pN_rvalid = 1 for exactly one cycle, for loads, stores and errors alike.
- rdata = mem_data captured at the grant edge for legal loads; 0 for stores and errors.
- rdata holds its value until the next response.
- pN_err = 1 alongside rvalid for illegal requests.

Latency: grant 0 cycles after req (when winning); response 1 cycle after grant.

Reset mid-operation: a pending response is dropped, with no rvalid after reset release.

Optional Feature:
Macro DMEM_ARB_LOCK_EN.

With the macro:
- Port p1_lock exists; FSM is ARB <-> LOCK1.
- Enter LOCK1: port 1 granted with p1_lock = 1.
- In LOCK1: port 0 is never granted; port 1 is granted whenever p1_req is high.
- lock_cnt increments every cycle in LOCK1.
- Exit to ARB when any of the following occurs:
  - port 1 is granted with p1_lock = 0 (that access still completes);
  - p1_lock drops while p1_req is low;
  - lock_cnt reaches LOCK_MAX-1, in which case the forced exit sets last_gnt = 1 so port 0 wins the next tie.
- lock_cnt clears on exit.

Without the macro: no p1_lock port, no LOCK1 state, LOCK_MAX unused.

Decomposition:
- Package dmem_arb_pkg holds:
  - arb_state_e {ARB, LOCK1};
  - funct3 localparams F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101;
  - response struct {valid, err, port}.
- One sub-module: dmem_req_check. It is purely combinational (addr, we, func3 -> legal), instantiated once on the muxed granted request.

Test Plan:
- Single request: p0 SW addr 0x08 data 0xDEADBEEF, then p0 LW 0x08 -> p0_gnt same cycle as req; rvalid next cycle; rdata = 0xDEADBEEF, err = 0.
- Tie: after reset, both req high for 4 cycles -> grants alternate p0, p1, p0, p1; each rvalid lands on the matching port one cycle later.
- Byte/half load: store 0x8000_FF80 at 0x10, then LB 0x10 -> 0xFFFFFF80; LBU 0x11 -> 0x000000FF; LH 0x12 -> 0xFFFF8000.
- Illegal request: p1 LW 0x06, LH 0x03, SW 0x80 -> each gets rvalid with p1_err = 1 and rdata = 0; mem_wr/mem_read stay 0; memory contents unchanged.
- Reset mid-op: rst_n low in the cycle after a grant -> no rvalid is issued; after release, the first tie grants p0.
- DMEM_ARB_LOCK_EN: p1 holds lock with req high and p0 req high -> p0 is starved for exactly 16 cycles, then granted on the next cycle.
